// File: rtl/aib_adapttxdp_word_mark.sv
// aib_adapttxdp_word_mark
// TX-datapath word sequencer and word-marker inserter, rd_clk domain.
// Pops groups of 1/2/4 words from a show-ahead TX FIFO and emits one
// DWIDTH-bit word per clock. In 2X/4X it can force a marker bit once per
// group so the far-end RX can word-align on the marker cadence.
// Optional build: define AIB_TXDP_UNDERRUN_CNT_EN to build the saturating
// underrun counter; otherwise underrun_cnt is tied to zero.
module aib_adapttxdp_word_mark #(
    parameter int DWIDTH = 80
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [1:0]            r_fifo_mode,
    input  logic                  r_wa_en,
    input  logic                  m_gen2_mode,
    input  logic [4:0]            r_mkbit,
    input  logic                  fifo_empty,
    input  logic [DWIDTH*4-1:0]   fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DWIDTH-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  underrun,
    output logic [7:0]            underrun_cnt
);

    localparam int NWORDS = 4;
    localparam int HALF   = DWIDTH / 2;

    typedef enum logic [1:0] {
        MODE_1X  = 2'b00,
        MODE_2X  = 2'b01,
        MODE_4X  = 2'b10,
        MODE_REG = 2'b11
    } fifo_mode_e;

    fifo_mode_e                        mode;
    logic [1:0]                        mode_q;
    logic                              mode_q_vld;
    logic                              mode_chg;
    logic [1:0]                        cnt;
    logic [1:0]                        cnt_nxt;
    logic [1:0]                        last_ph;
    logic                              boundary;
    logic                              pop;
    logic                              armed;
    logic                              urun_hit;
    logic                              mark_en;
    logic [NWORDS-1:0][DWIDTH-1:0]     hold;
    logic                              grp_vld;
    logic [DWIDTH-1:0]                 fifo_w0;
    logic [DWIDTH-1:0]                 mk_mask;
    logic [DWIDTH-1:0]                 word_raw;
    logic [DWIDTH-1:0]                 word_out;
    logic                              word_vld;

    assign mode    = fifo_mode_e'(r_fifo_mode);
    assign fifo_w0 = fifo_rd_data[DWIDTH-1:0];

    // mode_q is only meaningful after the first clock out of reset, so the
    // first boundary after reset can pop regardless of the configured mode.
    assign mode_chg = mode_q_vld && (r_fifo_mode != mode_q);

    // A mode change steals the boundary: popping there would lose the group
    // because the hold register is discarded on the same edge.
    assign boundary   = (cnt == 2'd0) && !mode_chg;
    assign fifo_rd_en = rd_rst_n && boundary && !fifo_empty;
    assign pop        = fifo_rd_en;
    assign urun_hit   = boundary && fifo_empty && armed;
    assign mark_en    = r_wa_en && ((mode == MODE_2X) || (mode == MODE_4X));

    // Last phase of the group and the free-running phase advance.
    always_comb begin
        last_ph = 2'd0;
        case (mode)
            MODE_4X: last_ph = 2'd3;
            MODE_2X: last_ph = 2'd1;
            default: last_ph = 2'd0;
        endcase
        cnt_nxt = (cnt == last_ph) ? 2'd0 : cnt + 2'd1;
    end

    // Decode the one-hot marker position; anything else disables the marker.
    always_comb begin
        mk_mask = '0;
        case (r_mkbit)
            5'b10000: mk_mask[DWIDTH-1] = 1'b1;
            5'b01000: mk_mask[DWIDTH-2] = 1'b1;
            5'b00100: mk_mask[DWIDTH-3] = 1'b1;
            5'b00010: mk_mask[DWIDTH-4] = 1'b1;
            5'b00001: mk_mask[HALF-1]   = 1'b1;
            default:  mk_mask = '0;
        endcase
    end

    // Word selection: phase 0 bypasses the FIFO output directly so word0
    // leaves one clock after the pop; later phases read the hold register.
    always_comb begin
        word_raw = '0;
        case (mode)
            MODE_4X: word_raw = (cnt == 2'd0) ? fifo_w0 : hold[cnt];
            MODE_2X: begin
                if (m_gen2_mode)
                    word_raw = (cnt == 2'd0) ? fifo_w0 : hold[1];
                else if (cnt == 2'd0)
                    word_raw = {{(DWIDTH-HALF){1'b0}}, fifo_w0[HALF-1:0]};
                else
                    word_raw = {{HALF{1'b0}}, hold[0][DWIDTH-1:HALF]};
            end
            default: word_raw = fifo_w0;
        endcase
    end

    // Idle masking and marker forcing; the marker is applied to idle groups
    // too so the far end never loses cadence.
    always_comb begin
        word_vld = mode_chg ? 1'b0 : ((cnt == 2'd0) ? pop : grp_vld);
        word_out = word_vld ? word_raw : '0;
        if (mark_en)
            word_out = (cnt == last_ph) ? (word_out | mk_mask) : (word_out & ~mk_mask);
        if (mode_chg)
            word_out = '0;
    end

    // Phase counter, group capture, output register and underrun flag.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            cnt        <= 2'd0;
            mode_q     <= 2'd0;
            mode_q_vld <= 1'b0;
            hold       <= '0;
            grp_vld    <= 1'b0;
            armed      <= 1'b0;
            underrun   <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
        end else begin
            mode_q     <= r_fifo_mode;
            mode_q_vld <= 1'b1;
            cnt        <= mode_chg ? 2'd0 : cnt_nxt;
            tx_data    <= word_out;
            tx_valid   <= word_vld;
            if (mode_chg) begin
                hold    <= '0;
                grp_vld <= 1'b0;
            end else if (boundary) begin
                grp_vld <= pop;
                if (pop)
                    hold <= fifo_rd_data;
            end
            if (pop)
                armed <= 1'b1;
            if (urun_hit)
                underrun <= 1'b1;
        end
    end

`ifdef AIB_TXDP_UNDERRUN_CNT_EN
    logic [7:0] urun_cnt_q;

    // Count every underrun boundary, saturating at all-ones.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n)
            urun_cnt_q <= 8'h00;
        else if (urun_hit && (urun_cnt_q != 8'hFF))
            urun_cnt_q <= urun_cnt_q + 8'h01;
    end

    assign underrun_cnt = urun_cnt_q;
`else
    assign underrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_aib_adapttxdp_word_mark.sv
// tb_aib_adapttxdp_word_mark
// Table-driven bench: each row is one clock of stimulus with the expected
// fifo_rd_en during that clock and the expected registered outputs after it.
module tb_aib_adapttxdp_word_mark;

    logic         rd_clk;
    logic         rd_rst_n;
    logic [1:0]   r_fifo_mode;
    logic         r_wa_en;
    logic         m_gen2_mode;
    logic [4:0]   r_mkbit;
    logic         fifo_empty;
    logic [319:0] fifo_rd_data;
    logic         fifo_rd_en;
    logic [79:0]  tx_data;
    logic         tx_valid;
    logic         underrun;
    logic [7:0]   underrun_cnt;

    int n_total = 0;
    int n_pass  = 0;

    aib_adapttxdp_word_mark #(.DWIDTH(80)) dut (
        .rd_clk       (rd_clk),
        .rd_rst_n     (rd_rst_n),
        .r_fifo_mode  (r_fifo_mode),
        .r_wa_en      (r_wa_en),
        .m_gen2_mode  (m_gen2_mode),
        .r_mkbit      (r_mkbit),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic         rst;
        logic [1:0]   mode;
        logic         wa;
        logic         gen2;
        logic [4:0]   mkb;
        logic         empty;
        logic [319:0] data;
        logic         rd;
        logic [79:0]  tx;
        logic         v;
        logic         u;
        logic [7:0]   c;
    } vec_t;

    localparam logic [79:0] W0  = 80'h0000_1111_2222_3333_4444;
    localparam logic [79:0] W1  = 80'h0101_0000_0000_0000_00A1;
    localparam logic [79:0] W2  = 80'h7FFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] W3  = 80'h3000_0000_0000_0000_0003;
    localparam logic [79:0] W3M = 80'hB000_0000_0000_0000_0003;
    localparam logic [79:0] ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] X1  = 80'h8000_0000_0000_0000_0001;
    localparam logic [79:0] X0M = 80'h7FFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] X1M = 80'h0000_0000_0000_0000_0001;
    localparam logic [79:0] M79 = 80'h8000_0000_0000_0000_0000;
    localparam logic [79:0] M77 = 80'h2000_0000_0000_0000_0000;
    localparam logic [79:0] M39 = 80'h0000_0000_0080_0000_0000;
    localparam logic [79:0] J   = 80'hFFFF_0000_FFFF_0000_FFFF;
    localparam logic [319:0] G1 = {W3, W2, W1, W0};
    localparam logic [319:0] G2 = {80'h0, 80'h0, X1, ONES};

    vec_t vecs[$];

    function automatic vec_t r(input logic rst, input logic [1:0] mode, input logic wa,
                               input logic gen2, input logic [4:0] mkb, input logic empty,
                               input logic [319:0] data, input logic rd, input logic [79:0] tx,
                               input logic v, input logic u, input logic [7:0] c);
        vec_t x;
        x.rst = rst; x.mode = mode; x.wa = wa; x.gen2 = gen2; x.mkb = mkb;
        x.empty = empty; x.data = data; x.rd = rd; x.tx = tx; x.v = v; x.u = u; x.c = c;
        return x;
    endfunction

    function automatic logic [7:0] ecnt(input logic [7:0] c);
`ifdef AIB_TXDP_UNDERRUN_CNT_EN
        return c;
`else
        return 8'h00 & c;
`endif
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rd_rst_n = 1'b0;
        @(posedge rd_clk);
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
    endtask

    task automatic run_row(input int idx, input vec_t v);
        r_fifo_mode  = v.mode;
        r_wa_en      = v.wa;
        m_gen2_mode  = v.gen2;
        r_mkbit      = v.mkb;
        fifo_empty   = v.empty;
        fifo_rd_data = v.data;
        if (v.rst) do_reset();
        #1;
        chk($sformatf("row%0d rd_en", idx), {79'h0, fifo_rd_en}, {79'h0, v.rd});
        @(posedge rd_clk);
        #1;
        chk($sformatf("row%0d tx_data", idx), tx_data, v.tx);
        chk($sformatf("row%0d tx_valid", idx), {79'h0, tx_valid}, {79'h0, v.v});
        chk($sformatf("row%0d underrun", idx), {79'h0, underrun}, {79'h0, v.u});
        chk($sformatf("row%0d underrun_cnt", idx), {72'h0, underrun_cnt}, {72'h0, ecnt(v.c)});
    endtask

    initial begin
        // A: 4X Gen2, marker bit 79, two groups then underrun
        vecs.push_back(r(1, 2'b10, 1, 1, 5'b10000, 0, G1,     1, W0,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W1,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W2,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W3M,   1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 0, G2,     1, X0M,   1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, X1M,   1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, M79,   1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, M79,   0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 2));
        // B: 2X Gen1 halves with bit-39 marker, then a Gen2 group, then underrun
        vecs.push_back(r(1, 2'b01, 1, 0, 5'b00001, 0,
                         {160'h0, 80'h1234_5678_9ABC_DEF0_1357, 80'h2AAA_AAAA_AAD5_5555_5555},
                         1, 80'h0000_0000_0055_5555_5555, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 0, 5'b00001, 1, 320'h0, 0, 80'h0000_0000_00AA_AAAA_AAAA, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b00001, 0,
                         {160'h0, 80'h1, 80'h0000_0000_00FF_FFFF_FFFF},
                         1, 80'h0000_0000_007F_FFFF_FFFF, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b00001, 1, 320'h0, 0, 80'h0000_0000_0080_0000_0001, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b00001, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b00001, 1, 320'h0, 0, M39,   0, 1, 1));
        // C: 1X, pop every clock, no marker even with r_wa_en set
        vecs.push_back(r(1, 2'b00, 1, 1, 5'b10000, 0, {J, J, J, ONES}, 1, ONES, 1, 0, 0));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 0, {J, J, J, M79},  1, M79,  1, 0, 0));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 0, {J, J, J, 80'h1}, 1, 80'h1, 1, 0, 0));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 0, {J, J, J, 80'h1234_5678_9ABC_DEF0_1234},
                         1, 80'h1234_5678_9ABC_DEF0_1234, 1, 0, 0));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 0, {J, J, J, 80'h0}, 1, 80'h0, 1, 0, 0));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b00, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 2));
        // D: 4X -> 2X switch at phase 2
        vecs.push_back(r(1, 2'b10, 1, 1, 5'b10000, 0, G1,     1, W0,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W1,    1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b10000, 0, {160'h0, 80'h42, ONES}, 1, X0M, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h8000_0000_0000_0000_0042, 1, 0, 0));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b01, 1, 1, 5'b10000, 1, 320'h0, 0, M79,   0, 1, 1));
        // E: 4X with r_wa_en=0, then invalid r_mkbit, then bit-77 marker
        vecs.push_back(r(1, 2'b10, 0, 1, 5'b10000, 0, G1,     1, W0,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 0, 1, 5'b10000, 1, 320'h0, 0, W1,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 0, 1, 5'b10000, 1, 320'h0, 0, W2,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 0, 1, 5'b10000, 1, 320'h0, 0, W3,    1, 0, 0));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00011, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00011, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00011, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00011, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00100, 1, 320'h0, 0, 80'h0, 0, 1, 2));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00100, 1, 320'h0, 0, 80'h0, 0, 1, 2));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00100, 1, 320'h0, 0, 80'h0, 0, 1, 2));
        vecs.push_back(r(0, 2'b10, 1, 1, 5'b00100, 1, 320'h0, 0, M77,   0, 1, 2));

        // Reset state, with a non-empty FIFO to show the pop is gated by reset
        rd_rst_n     = 1'b0;
        r_fifo_mode  = 2'b10;
        r_wa_en      = 1'b1;
        m_gen2_mode  = 1'b1;
        r_mkbit      = 5'b10000;
        fifo_empty   = 1'b0;
        fifo_rd_data = G1;
        #12;
        chk("reset tx_data", tx_data, 80'h0);
        chk("reset tx_valid", {79'h0, tx_valid}, 80'h0);
        chk("reset underrun", {79'h0, underrun}, 80'h0);
        chk("reset underrun_cnt", {72'h0, underrun_cnt}, 80'h0);
        chk("reset rd_en", {79'h0, fifo_rd_en}, 80'h0);

        for (int i = 0; i < vecs.size(); i++)
            run_row(i, vecs[i]);

        // Reset asserted mid-group after an underrun, then first pop on release
        run_row(100, r(1, 2'b10, 1, 1, 5'b10000, 0, G1,     1, W0,    1, 0, 0));
        run_row(101, r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W1,    1, 0, 0));
        run_row(102, r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W2,    1, 0, 0));
        run_row(103, r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, W3M,   1, 0, 0));
        run_row(104, r(0, 2'b10, 1, 1, 5'b10000, 1, 320'h0, 0, 80'h0, 0, 1, 1));
        fifo_empty   = 1'b0;
        fifo_rd_data = G2;
        #1;
        chk("midgroup no pop", {79'h0, fifo_rd_en}, 80'h0);
        rd_rst_n = 1'b0;
        #1;
        chk("midrst tx_data", tx_data, 80'h0);
        chk("midrst tx_valid", {79'h0, tx_valid}, 80'h0);
        chk("midrst underrun", {79'h0, underrun}, 80'h0);
        chk("midrst underrun_cnt", {72'h0, underrun_cnt}, 80'h0);
        chk("midrst rd_en", {79'h0, fifo_rd_en}, 80'h0);
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
        #1;
        chk("release first pop", {79'h0, fifo_rd_en}, 80'h1);
        @(posedge rd_clk);
        #1;
        chk("release tx_data", tx_data, X0M);
        chk("release tx_valid", {79'h0, tx_valid}, 80'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aib_adapttxdp_word_mark.md
# aib_adapttxdp_word_mark

TX-datapath word sequencer and word-marker inserter. It pops wide groups of 1, 2 or 4 words from the TX FIFO read port and emits one DWIDTH-bit word per clock toward the AIB IO. When enabled, it forces the configured marker bit once per group so the far-end RX datapath can detect the marker cadence and word-align. It runs entirely in the TX read clock domain.

## Interface
Parameters:
- DWIDTH, 80, width of one transmitted word; group input is DWIDTH*4.

Ports:
- rd_clk  in  1  TX read-domain clock.
- rd_rst_n  in  1  asynchronous, active-low reset.
- r_fifo_mode  in  2  00 = FIFO_1X, 01 = FIFO_2X, 10 = FIFO_4X, 11 = REG mode.
- r_wa_en  in  1  marker insertion enable.
- m_gen2_mode  in  1  1 = Gen2 80-bit words; 0 = Gen1 (2X carries 40-bit halves).
- r_mkbit  in  5  one-hot marker position: 10000 = bit 79, 01000 = bit 78, 00100 = bit 77, 00010 = bit 76, 00001 = bit 39; any other value = no marker.
- fifo_empty  in  1  TX FIFO empty; fifo_rd_data is valid when this is low (show-ahead).
- fifo_rd_data  in  DWIDTH*4  group, word k = bits [DWIDTH*(k+1)-1 : DWIDTH*k].
- fifo_rd_en  out  1  pop strobe; combinational.
- tx_data  out  DWIDTH  registered output word.
- tx_valid  out  1  tx_data carries FIFO data (0 = idle word).
- underrun  out  1  sticky; an empty FIFO was seen at a group boundary after the first group.
- underrun_cnt  out  8  saturating underrun count (see Configuration).

## Operation
- Group size G: 4X = 4; 2X = 2; 1X and REG = 1. A 2-bit phase counter cnt advances by 1 every clock, modulo G, regardless of FIFO state.
- Boundary (cnt == 0):
  - fifo_rd_en = !fifo_empty; it is 0 in every other phase and whenever rd_rst_n is low.
  - On a pop, fifo_rd_data is captured into the hold register.
  - If the FIFO is empty, the whole group is idle: data is 0 and tx_valid = 0 for all G words.
- Word selection, phase p:
  - 4X, and 2X with Gen2: word p.
  - 2X with Gen1: p = 0 sends {40'h0, word0[39:0]}; p = 1 sends {40'h0, word0[79:40]}.
  - 1X and REG: word0.
- Marker, applied when r_wa_en = 1 and the mode is 2X or 4X:
  - The selected bit is forced to 1 on the last phase of the group (p = G-1) and to 0 on all other phases.
  - This applies to idle groups as well, so the cadence never breaks.
  - With r_wa_en = 0, or in 1X/REG, data passes unmodified.
- underrun:
  - Arms after the first successful pop.
  - Sets on any later boundary where fifo_empty = 1.
  - Cleared only by reset.
- Mode change: if r_fifo_mode differs from its registered copy, cnt is forced to 0 on the next clock, the hold register is discarded, and that output word is idle.

## Timing
- Reset values: tx_data = 0, tx_valid = 0, underrun = 0, underrun_cnt = 0, cnt = 0, hold = 0, fifo_rd_en = 0.
- Latency: word0 of a popped group appears on tx_data one rd_clk after the pop edge. Words 1..G-1 follow on consecutive clocks with no gaps.
- Throughput: 4X pops at most once every 4 clocks; 2X once every 2; 1X/REG every clock.
- FIFO going non-empty mid-group: no pop occurs until the next boundary.
- Reset asserted mid-group: the group is dropped; after release, cnt restarts at 0.
- The first output clock after reset is a boundary.

## Configuration
- AIB_TXDP_UNDERRUN_CNT_EN defined:
  - underrun_cnt increments on every boundary that sets or re-asserts the underrun condition.
  - It saturates at 8'hFF and resets to 0.
- Not defined: underrun_cnt is tied to 8'h00 and no counter flops are built. The port is always present.

## Test plan
- 4X, Gen2, r_wa_en = 1, r_mkbit = 10000, FIFO holds group {W3,W2,W1,W0} with bit 79 clear -> pop at t0; tx_data = W0, W1, W2, W3 at t1..t4; bit 79 = 0,0,0,1; tx_valid = 1 throughout.
- 2X, Gen1, r_mkbit = 00001, word0 = 80'hAAAA_..._5555 -> tx_data[39:0] = lower half, then upper half with bit 39 forced to 1; bits [79:40] = 0.
- 4X, FIFO empty after the first group -> the next four words are 0 with tx_valid = 0; bit 79 pattern 0001 continues; underrun rises at the boundary; underrun_cnt = 1 with the macro, 0 without.
- 1X, FIFO non-empty for 5 clocks -> fifo_rd_en high for 5 clocks; tx_data equals each word0 one clock later; no marker bits forced.
- Switch from 4X to 2X at phase 2 -> one idle word; cnt = 0 on the next clock; 2X cadence 0101 on bit 79 thereafter.
- Assert rd_rst_n low at phase 1 of 4X -> all outputs return to reset values immediately; the first pop after release happens on the first clock.
